// File: rtl/morse_timebase.sv
// Morse front end: unit time-base, debounced START pulse and BUSY message window.
// Optional define MORSE_RETRIGGER_EN lets a press during an active window restart it.
module morse_timebase #(
    parameter int unsigned UNIT_DIV  = 25000000,
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_n_i,
    input  logic [2:0] units_i,
    output logic       tick_o,
    output logic       start_o,
    output logic       busy_o,
    output logic [2:0] unit_idx_o,
    output logic       key_level_o
);

    localparam int unsigned PreW = (UNIT_DIV > 2) ? $clog2(UNIT_DIV) : 1;
    localparam int unsigned DbW  = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(UNIT_DIV - 1);
    localparam logic [DbW-1:0]  DbMax  = DbW'(DB_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic            tick_q, start_q;
    state_e          state_q, state_d;
    logic [2:0]      len_q, len_d;
    logic [2:0]      idx_q, idx_d;
    logic            press;
    logic            accept;
    logic            unit_tick;

    // Two-flop synchronizer; both flops reset to the released level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= key_n_i;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (s2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbMax) begin
            stable_d = s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign press = stable_q & ~stable_d;

`ifdef MORSE_RETRIGGER_EN
    assign accept = press;
`else
    assign accept = press & (state_q == StIdle);
`endif

    // An accepted press restarts the unit phase, so no tick can coincide with it.
    assign unit_tick = (pre_q == PreMax) & ~accept;

    always_comb begin
        pre_d = pre_q + 1'b1;
        if (accept || (pre_q == PreMax)) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stable_q <= 1'b1;
            db_cnt_q <= '0;
            pre_q    <= '0;
            tick_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            pre_q    <= pre_d;
            tick_q   <= unit_tick;
            start_q  <= accept;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (accept && (units_i != 3'd0)) begin
                    state_d = StActive;
                    len_d   = units_i;
                    idx_d   = 3'd0;
                end
            end
            StActive: begin
                if (accept) begin
                    len_d = units_i;
                    idx_d = 3'd0;
                    if (units_i == 3'd0) begin
                        state_d = StIdle;
                    end
                end else if (unit_tick) begin
                    if ((idx_q + 3'd1) == len_q) begin
                        state_d = StIdle;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = 3'd0;
            end
        endcase
    end

    // FSM outputs; all are straight from registers.
    always_comb begin
        busy_o      = (state_q == StActive);
        unit_idx_o  = idx_q;
        tick_o      = tick_q;
        start_o     = start_q;
        key_level_o = ~stable_q;
    end

endmodule

// File: tb/tb_morse_timebase.sv
// Directed bench for morse_timebase with UNIT_DIV=4, DB_CYCLES=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_morse_timebase;

    localparam int unsigned UnitDiv  = 4;
    localparam int unsigned DbCycles = 3;
`ifdef MORSE_RETRIGGER_EN
    localparam bit Retrig = 1'b1;
`else
    localparam bit Retrig = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_n = 1'b1;
    logic [2:0] units = 3'd0;
    logic       tick, start, busy, key_level;
    logic [2:0] unit_idx;

    int errors = 0;
    int checks = 0;

    morse_timebase #(
        .UNIT_DIV (UnitDiv),
        .DB_CYCLES(DbCycles)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .key_n_i    (key_n),
        .units_i    (units),
        .tick_o     (tick),
        .start_o    (start),
        .busy_o     (busy),
        .unit_idx_o (unit_idx),
        .key_level_o(key_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic bounce [5];
    int   k;
    logic [2:0] exp_idx;
    logic       exp_tick;

    initial begin
        bounce = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Power-on reset values.
        cyc(2);
        chk("rst_tick", tick, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", unit_idx, 0);
        chk("rst_level", key_level, 0);
        rst = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            cyc(1);
            chk("boot_tick", tick, (j == 4 || j == 8));
            chk("boot_start", start, 0);
        end

        // Clean press with a 5-unit window.
        units = 3'd5;
        key_n = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cyc(1);
            chk("press_start", start, (j == 5));
            chk("press_busy", busy, (j == 5));
            chk("press_level", key_level, (j == 5));
        end
        chk("press_idx0", unit_idx, 0);
        for (int kk = 1; kk <= 21; kk++) begin
            cyc(1);
            chk("win_busy", busy, (kk < 20));
            chk("win_tick", tick, (kk % 4 == 0));
            chk("win_idx", unit_idx, (kk < 20) ? kk / 4 : 0);
            chk("win_start", start, 0);
        end
        key_n = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cyc(1);
            chk("rel_level", key_level, (j < 5));
            chk("rel_start", start, 0);
        end

        // Bounce shorter than the debounce window is rejected.
        for (int j = 0; j < 15; j++) begin
            key_n = (j < 5) ? bounce[j] : 1'b1;
            cyc(1);
            chk("bounce_start", start, 0);
            chk("bounce_level", key_level, 0);
        end

        // UNITS=0 press: START only.
        units = 3'd0;
        key_n = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cyc(1);
            chk("zero_start", start, (j == 5));
            chk("zero_busy", busy, 0);
        end
        key_n = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cyc(1);
            chk("zero_busy2", busy, 0);
            chk("zero_start2", start, 0);
        end

        // UNITS=3 window, second press while active, UNITS wiggled mid-window.
        units = 3'd3;
        key_n = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cyc(1);
            chk("act_start", start, (j == 5));
        end
        key_n = 1'b1;
        for (int kk = 1; kk <= 24; kk++) begin
            cyc(1);
            chk("act2_start", start, (Retrig && kk == 10));
            chk("act2_busy", busy, Retrig ? (kk < 22) : (kk < 12));
            if (kk == 2) units = 3'd7;
            if (kk == 5) key_n = 1'b0;
            if (kk == 7) units = 3'd3;
        end
        key_n = 1'b1;
        cyc(8);

        // UNITS=2, quick release and re-press landing at UNIT_IDX=1.
        units = 3'd2;
        key_n = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            cyc(1);
            k = j - 5;
            if (Retrig)
                exp_idx = ((k >= 4 && k < 6) || (k >= 10 && k < 14)) ? 3'd1 : 3'd0;
            else
                exp_idx = (k >= 4 && k < 8) ? 3'd1 : 3'd0;
            exp_tick = Retrig ? (k == 4 || (k >= 10 && (k - 10) % 4 == 0))
                              : (k % 4 == 0);
            chk("rt_start", start, (k == 0 || (Retrig && k == 6)));
            chk("rt_busy", busy, (k >= 0 && k < (Retrig ? 14 : 8)));
            chk("rt_idx", unit_idx, exp_idx);
            chk("rt_level", key_level, ((j >= 5 && j < 8) || j >= 11));
            if (k > 0) chk("rt_tick", tick, exp_tick);
            if (j == 3) key_n = 1'b1;
            if (j == 6) key_n = 1'b0;
        end
        key_n = 1'b1;
        cyc(8);

        // Reset asserted mid-window.
        units = 3'd7;
        key_n = 1'b0;
        cyc(5);
        chk("mid_start", start, 1);
        key_n = 1'b1;
        cyc(3);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tick", tick, 0);
        chk("mid_rst_start", start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_idx", unit_idx, 0);
        chk("mid_rst_level", key_level, 0);
        cyc(1);
        rst = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            cyc(1);
            chk("post_tick", tick, (j == 4 || j == 8));
            chk("post_start", start, 0);
            chk("post_busy", busy, 0);
            chk("post_level", key_level, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
